// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the datapath and its RAM.
// The master drives requests; the slave answers with ready/stall/err/rdata.
interface data_mem_responder_if #(
  parameter int DATA_W = 16
);
  logic              mem_read;
  logic              mem_write;
  logic [15:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              stall;
  logic              err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, stall, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, stall, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed synchronous data RAM with fixed-latency ready/stall handshake.
// Optional bounds checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [DATA_W-1:0] OOB_DATA = DATA_W'(16'hDEAD);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oob_q;

  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  logic              req;
  logic              oob_in;
  logic [ADDR_W-1:0] idx_in;

  logic              stall_c;
  logic              latch;
  logic              commit;
  logic              c_wr;
  logic [ADDR_W-1:0] c_idx;
  logic [DATA_W-1:0] c_wdata;
  logic              c_oob;

  assign req    = bus.mem_read | bus.mem_write;
  assign idx_in = bus.addr[ADDR_W:1];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob_in = (bus.addr >> (ADDR_W + 1)) != 16'd0;
  logic unused_addr;
  assign unused_addr = bus.addr[0];
`else
  assign oob_in = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.addr >> (ADDR_W + 1), bus.addr[0]};
`endif

  // With zero wait states the commit edge is the accept edge,
  // so the live inputs are used instead of the latched copy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    latch   = 1'b0;
    commit  = 1'b0;
    c_wr    = wr_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_oob   = oob_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          latch   = 1'b1;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
            c_wr    = bus.mem_write;
            c_idx   = idx_in;
            c_wdata = bus.wdata;
            c_oob   = oob_in;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = 4'(cnt_q - 4'd1);
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      err_q   <= commit & c_oob;
      if (latch) begin
        wr_q    <= bus.mem_write;
        idx_q   <= idx_in;
        wdata_q <= bus.wdata;
        oob_q   <= oob_in;
      end
      if (commit && !c_wr) begin
        rdata_q <= c_oob ? OOB_DATA : mem[c_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && c_wr && !c_oob) begin
      mem[c_idx] <= c_wdata;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.stall = stall_c;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: vector table, multi-cycle corner sequences and
// random traffic against a word-array reference model.
module tb_data_mem_responder;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_W(16)) dif ();
  data_mem_responder_if #(.DATA_W(16)) dif0 ();

  data_mem_responder #(
    .DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(dif.slave)
  );

  data_mem_responder #(
    .DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(dif0.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] model_mem [256];
  logic [15:0] model_rd;

  function automatic logic [15:0] initval(input int i);
    return 16'(i * 16'h0101) ^ 16'h3C5A;
  endfunction

  // Spec rules: write wins, out-of-range writes dropped,
  // out-of-range reads give DEAD, writes leave rdata alone.
  task automatic model_step(input bit rd, input bit wr,
                            input logic [15:0] a,
                            input logic [15:0] d,
                            output logic [15:0] er,
                            output bit ee);
    bit oob;
    int idx;
    oob = BCHK && (a >= 16'h0200);
    idx = int'(a[8:1]);
    if (wr) begin
      if (!oob) model_mem[idx] = d;
    end else if (rd) begin
      model_rd = oob ? 16'hDEAD : model_mem[idx];
    end
    er = model_rd;
    ee = oob;
  endtask

  task automatic txn(input bit rd, input bit wr,
                     input logic [15:0] a,
                     input logic [15:0] d,
                     output logic [15:0] rq,
                     output bit e,
                     output int lat,
                     output int sc);
    bit got;
    got = 1'b0;
    lat = 0;
    sc  = 0;
    @(negedge clk);
    dif.mem_read  = rd;
    dif.mem_write = wr;
    dif.addr      = a;
    dif.wdata     = d;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (dif.stall) sc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (dif.ready) begin
        got = 1'b1;
        break;
      end
    end
    check("txn_done", 32'(got), 32'd1);
    rq = dif.rdata;
    e  = dif.err;
    check("stall_in_resp", 32'(dif.stall), 32'd0);
    dif.mem_read  = 1'b0;
    dif.mem_write = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [15:0] rq, er;
    bit          e, ee;
    int          lat, sc;
    int          nrdy, last;

    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h0020, 16'h00AA, 16'hBEEF, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h00AA, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h01FE, 16'h7777, 16'hBEEF, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 16'h01FE, 16'h0000, 16'h7777, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 16'h0200, 16'h5555, 16'h7777, BCHK};
    tbl[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000,
               BCHK ? 16'h3C5A : 16'h5555, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 16'h0200, 16'h0000,
               BCHK ? 16'hDEAD : 16'h5555, BCHK};

    reset = 1'b1;
    dif.mem_read = 1'b0;  dif.mem_write = 1'b0;
    dif.addr = '0;        dif.wdata = '0;
    dif0.mem_read = 1'b0; dif0.mem_write = 1'b0;
    dif0.addr = '0;       dif0.wdata = '0;
    model_rd = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", 32'(dif.rdata), 32'h0);
    check("rst_ready", 32'(dif.ready), 32'h0);
    check("rst_stall", 32'(dif.stall), 32'h0);
    check("rst_err",   32'(dif.err),   32'h0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) begin
      txn(1'b0, 1'b1, 16'(i * 2), initval(i), rq, e, lat, sc);
      model_mem[i] = initval(i);
    end
    check("init_rdata", 32'(dif.rdata), 32'h0);

    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d,
          rq, e, lat, sc);
      model_step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d,
                 er, ee);
      check($sformatf("vec%0d_rdata", i), 32'(rq), 32'(tbl[i].er));
      check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].ee));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_stall", i), 32'(sc), 32'd3);
    end

    // T1: reset in the middle of a write's wait states
    @(negedge clk);
    dif.mem_write = 1'b1;
    dif.addr      = 16'h0004;
    dif.wdata     = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    dif.mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_rdata", 32'(dif.rdata), 32'h0);
    check("t1_ready", 32'(dif.ready), 32'h0);
    check("t1_stall", 32'(dif.stall), 32'h0);
    check("t1_err",   32'(dif.err),   32'h0);
    reset = 1'b0;
    model_rd = 16'h0000;
    txn(1'b1, 1'b0, 16'h0004, 16'h0000, rq, e, lat, sc);
    model_step(1'b1, 1'b0, 16'h0004, 16'h0000, er, ee);
    check("t1_old_data", 32'(rq), 32'(initval(2)));

    // T4: request held through RESP; ready every 4 cycles
    @(negedge clk);
    dif.mem_read = 1'b1;
    dif.addr     = 16'h0010;
    nrdy = 0;
    last = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (dif.ready) begin
        nrdy++;
        check("t4_ready_pos", 32'(n - last), nrdy == 1 ? 32'd3 : 32'd4);
        check("t4_rdata", 32'(dif.rdata), 32'hBEEF);
        check("t4_resp_stall", 32'(dif.stall), 32'd0);
        last = n;
      end
    end
    check("t4_nready", 32'(nrdy), 32'd3);
    #1;
    check("t4_accept_after", 32'(dif.stall), 32'd1);
    dif.mem_read = 1'b0;
    model_step(1'b1, 1'b0, 16'h0010, 16'h0000, er, ee);

    // T5: zero wait states
    @(negedge clk);
    dif0.mem_write = 1'b1;
    dif0.addr      = 16'h0002;
    dif0.wdata     = 16'h4321;
    #1;
    check("t5_w_stall", 32'(dif0.stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("t5_w_ready", 32'(dif0.ready), 32'd1);
    check("t5_w_stall_resp", 32'(dif0.stall), 32'd0);
    dif0.mem_write = 1'b0;
    @(negedge clk);
    dif0.mem_read = 1'b1;
    #1;
    check("t5_r_stall", 32'(dif0.stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("t5_r_ready", 32'(dif0.ready), 32'd1);
    check("t5_r_rdata", 32'(dif0.rdata), 32'h4321);
    dif0.mem_read = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      int          op;
      logic [15:0] a, d;
      op = int'($urandom_range(0, 2));
      a  = 16'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      d  = 16'($urandom);
      txn(op != 1, op != 0, a, d, rq, e, lat, sc);
      model_step(op != 1, op != 0, a, d, er, ee);
      check("rnd_rdata", 32'(rq), 32'(er));
      check("rnd_err", 32'(e), 32'(ee));
      check("rnd_lat", 32'(lat), 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
